traffic_controller: RTL and testbench

//  Timed two-road intersection sequencer. Produces the 3-bit light-state code consumed by the

---
 rtl/traffic_pkg.sv | 14 +
 rtl/traffic_controller_dwell_timer.sv | 19 +
 rtl/traffic_controller.sv | 63 ++++++
 tb/tb_traffic_controller.sv | 132 +++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes shared with the downstream decoder and the sequencer state encoding
package traffic_pkg;
  localparam logic [2:0] RR = 3'd0;
  localparam logic [2:0] GG = 3'd1;
  localparam logic [2:0] YY = 3'd2;
  localparam logic [2:0] GR = 3'd3;
  localparam logic [2:0] YR = 3'd4;
  localparam logic [2:0] RG = 3'd5;
  localparam logic [2:0] RY = 3'd6;
  typedef enum logic [2:0] {ALLRED, G1, Y1, G2, Y2, EMERG, FLASH_ON, FLASH_OFF} fsm_t;
  function automatic logic [2:0] light_code(input fsm_t s);
    return s == G1 ? GR : s == Y1 ? YR : s == G2 ? RG : s == Y2 ? RY : s == FLASH_ON ? YY : RR;
  endfunction
endpackage

// File: rtl/traffic_controller_dwell_timer.sv
// dwell_timer: down-counter holding ticks left in a dwell; expires on a tick at zero
module dwell_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             tick,
  output logic [CNT_W-1:0] remaining,
  output logic             expire
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) remaining <= RST_VAL;
    else if (load) remaining <= value;
    else if (tick && remaining != '0) remaining <= remaining - CNT_W'(1);
  assign expire = tick && remaining == '0;
endmodule

// File: rtl/traffic_controller.sv
// traffic_controller: two-road intersection sequencer with emergency all-red and night flashing
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_FLASH  = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             emergency,
  input  logic             night_mode,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_done
);
  localparam logic [CNT_W-1:0] L_G = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] L_Y = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_A = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] L_F = CNT_W'(T_FLASH - 1);
  fsm_t fsm, nxt;
  logic next_road;
  logic expire, load, pd;
  logic [CNT_W-1:0] val;
  dwell_timer #(.CNT_W(CNT_W), .RST_VAL(L_A)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .value(val), .tick(tick),
    .remaining(remaining), .expire(expire)
  );
  always_comb begin
    nxt = fsm;
    case (fsm)
      ALLRED:    if (expire) nxt = emergency ? EMERG : night_mode ? FLASH_ON : next_road ? G1 : G2;
      G1:        if (emergency || expire) nxt = Y1;
      G2:        if (emergency || expire) nxt = Y2;
      Y1, Y2:    if (expire) nxt = emergency ? EMERG : ALLRED;
      EMERG:     if (!emergency) nxt = ALLRED;
      FLASH_ON:  if (emergency) nxt = EMERG; else if (expire) nxt = FLASH_OFF;
      FLASH_OFF: if (emergency) nxt = EMERG; else if (expire) nxt = night_mode ? FLASH_ON : ALLRED;
      default:   nxt = ALLRED;
    endcase
    load = nxt != fsm;
    val = nxt inside {G1, G2} ? L_G : nxt inside {Y1, Y2} ? L_Y : nxt == ALLRED ? L_A :
          nxt inside {FLASH_ON, FLASH_OFF} ? L_F : '0;
    // preemption by emergency is not a dwell expiry, so it never pulses phase_done
    pd = expire && fsm != EMERG && !(emergency && fsm inside {G1, G2, FLASH_ON, FLASH_OFF});
  end
  // next_road=1 selects road 1 for the coming green
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm        <= ALLRED;
      state      <= RR;
      phase_done <= 1'b0;
      next_road  <= 1'b1;
    end else begin
      fsm        <= nxt;
      state      <= light_code(nxt);
      phase_done <= pd;
      if (fsm inside {Y1, Y2} && nxt != fsm) next_road <= ~next_road;
    end
endmodule

// File: tb/tb_traffic_controller.sv
// tb_traffic_controller: directed checks of cycling, tick gating, emergency, night mode and async reset
module tb_traffic_controller;
  logic clk = 1'b0;
  logic rst_n, tick, emergency, night_mode;
  logic [2:0] state;
  logic [7:0] remaining;
  logic phase_done;
  int total = 0;
  int bad = 0;

  traffic_controller #(.T_GREEN(3), .T_YELLOW(1), .T_ALLRED(1), .T_FLASH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .emergency(emergency), .night_mode(night_mode),
    .state(state), .remaining(remaining), .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk3(input string tag, input int s, input int r, input int p);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".rem"}, 32'(remaining), 32'(r));
    chk({tag, ".pd"}, 32'(phase_done), 32'(p));
  endtask

  int e1s[11] = '{3, 3, 3, 4, 0, 5, 5, 5, 6, 0, 3};
  int e1r[11] = '{2, 1, 0, 0, 0, 2, 1, 0, 0, 0, 2};
  int e1p[11] = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
  int e2s[6]  = '{3, 3, 3, 4, 0, 5};
  int e2r[6]  = '{2, 1, 0, 0, 0, 2};
  int e4s[15] = '{3, 3, 3, 4, 0, 2, 2, 0, 0, 2, 2, 0, 0, 0, 5};
  int e4r[15] = '{2, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 2};
  int e4p[15] = '{1, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};

  initial begin
    rst_n = 1'b0; tick = 1'b1; emergency = 1'b0; night_mode = 1'b0;
    step();
    chk3("reset", 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      chk3($sformatf("cycle[%0d]", i), e1s[i], e1r[i], e1p[i]);
    end

    do_reset();
    for (int t = 0; t < 6; t++) begin
      tick = 1'b0;
      repeat (3) step();
      chk3($sformatf("hold[%0d]", t), t == 0 ? 0 : e2s[t-1], t == 0 ? 0 : e2r[t-1], 0);
      tick = 1'b1;
      step();
      chk($sformatf("slow[%0d].state", t), 32'(state), 32'(e2s[t]));
      chk($sformatf("slow[%0d].rem", t), 32'(remaining), 32'(e2r[t]));
    end

    do_reset();
    repeat (2) step();
    chk3("emg.gr", 3, 1, 0);
    emergency = 1'b1;
    step();
    chk3("emg.preempt", 4, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk3($sformatf("emg.hold[%0d]", i), 0, 0, i == 0 ? 1 : 0);
    end
    emergency = 1'b0;
    step();
    chk3("emg.allred", 0, 0, 0);
    step();
    chk3("emg.resume", 5, 2, 1);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      step();
      chk3($sformatf("night[%0d]", i), e4s[i], e4r[i], e4p[i]);
      if (i == 0) night_mode = 1'b1;
      if (i == 9) night_mode = 1'b0;
    end

    night_mode = 1'b1;
    do_reset();
    step();
    chk3("both.flash", 2, 1, 1);
    emergency = 1'b1;
    step();
    chk3("both.emerg", 0, 0, 0);
    repeat (3) step();
    chk3("both.hold", 0, 0, 0);
    emergency = 1'b0;
    step();
    chk3("both.allred", 0, 0, 0);
    step();
    chk3("both.flash_again", 2, 1, 1);
    night_mode = 1'b0;

    do_reset();
    repeat (9) step();
    chk("arst.pre", 32'(state), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk3("arst.ry", 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk3("arst.restart", 3, 2, 1);
    #2 rst_n = 1'b0;
    #1;
    chk3("arst.gr", 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk3("arst.restart2", 3, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
